imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Writer side of the CPU instruction memory. Receives a program as a byte stream over a valid/ready link, for example from a UART RX.
//   It assembles little-endian 32-bit instruction words and writes them sequentially into instruction RAM.
//   Before loading, it fills the whole memory with NOP. It holds the CPU in reset until the load completes.
// PARAMETERS
//   ADDR_W     8              instruction memory word-address width
//   DEPTH      256            number of words; must be <= 2**ADDR_W and <= 256
//   NOP_WORD   32'h00000013   fill value (addi x0,x0,0)
//   BOOT_HOLD  1              reset value of cpu_hold (1 = CPU held until first load completes)
// PORTS
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous reset, active-high
//   start        in   1       pulse; begins clear+load when not busy
//   rx_data      in   8       stream byte
//   rx_valid     in   1       rx_data valid
//   rx_ready     out  1       byte accepted when rx_valid && rx_ready
//   we           out  1       instruction memory write enable
//   waddr        out  ADDR_W  word address
//   wdata        out  32      word to write
//   cpu_hold     out  1       1 = CPU must stay in reset / stall fetch
//   busy         out  1       1 in any state other than IDLE
//   done         out  1       one-cycle pulse at load completion
//   err          out  1       sticky: header count exceeded DEPTH; cleared by next accepted start
//   words_loaded out  9       words written in the last load (0..256)
// BEHAVIOUR
//   Reset values
//     we=0, waddr=0, wdata=0, rx_ready=0, busy=0, done=0, err=0, words_loaded=0.
//     cpu_hold=BOOT_HOLD; FSM=IDLE.
//     A reset mid-operation aborts immediately; partially written memory stays as-is.
//   Registered outputs
//     All outputs are registered; none depends combinationally on inputs.
//   FSM: IDLE -> CLEAR -> COUNT -> BYTES <-> WRITE -> DONE -> IDLE
//   IDLE
//     start=1 -> CLEAR; cpu_hold=1, err=0, word index=0.
//     start in any other state is ignored.
//   CLEAR
//     we=1, wdata=NOP_WORD, waddr=0..DEPTH-1, one per cycle (DEPTH cycles).
//     After the DEPTH-1 write -> COUNT.
//   COUNT
//     rx_ready=1. The accepted byte is N, the word count; 0 means none.
//     N=0 -> DONE.
//     N>DEPTH -> err=1 and N is clamped to DEPTH.
//     Otherwise -> BYTES.
//   BYTES
//     rx_ready=1. Byte k (0..3) of the current word goes to bits [8k+7:8k] (little-endian).
//     Cycles with rx_valid=0 stall indefinitely without side effects.
//     Accepting byte 3 -> WRITE.
//   WRITE (1 cycle)
//     rx_ready=0, we=1, waddr=word index, wdata=assembled word.
//     we rises the cycle after byte 3 is accepted.
//     Index increments. If index == N-1 -> DONE, else -> BYTES.
//   DONE (1 cycle)
//     done=1, cpu_hold=0, words_loaded=N (clamped), busy=0 next cycle.
//     -> IDLE. Bytes beyond N (or beyond the clamp) are never accepted.
//   Other-state defaults
//     rx_ready=0 and we=0 outside the states above.
//   Width rules
//     Word index is ADDR_W+1 bits so that DEPTH=256 terminates without wrap.
//     waddr never exceeds DEPTH-1.
//   Simultaneous events
//     start together with rx_valid in IDLE: the byte is not consumed.
//     rst dominates everything.
// TESTING
//   1. Reset mid-idle -> all outputs at reset values, cpu_hold=1 (BOOT_HOLD=1), rx_ready=0.
//   2. start; stream 02,93,02,00,00,83,22,90,02
//      -> 256 NOP writes at addr 0..255;
//      -> addr0=0x00000293, addr1=0x02902283;
//      -> done pulse, words_loaded=2, cpu_hold=0.
//   3. Same stream as test 2 with random 0-5 idle cycles between bytes -> identical write sequence; no write without 4 accepted bytes.
//   4. Header 00 -> only the 256-cycle clear; done, words_loaded=0; next byte not accepted (rx_ready=0).
//   5. DEPTH=16, header 0x14 -> err=1, 16 words written at addr 0..15, done; the 65th data byte is never accepted.
//   6. rst asserted in BYTES after 2 data bytes -> immediate reset values.
//      A new start then fully reloads correctly. A start pulse during CLEAR is ignored.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the program loader.
// The loader drives the master side. The byte source and the RAM sit on the slave side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, we, waddr, wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: NOP-fills the RAM, then writes a count-prefixed stream of
// little-endian 32-bit words into it. The CPU is held until the load completes.
module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
  parameter bit          BOOT_HOLD = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  imem_loader_if.master       bus,
  output logic                cpu_hold_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [8:0]          words_loaded_o
);

  localparam int                IW        = ADDR_W + 1;
  localparam logic [8:0]        DEPTH9    = 9'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COUNT, S_BYTES, S_WRITE, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [8:0]        words_q, words_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [8:0]        n_q, n_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic              accept;

  // rx_ready is a register, so a byte is taken only in cycles where it was already offered.
  assign accept = bus.rx_valid && rx_ready_q;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    hold_d  = hold_q;
    err_d   = err_q;
    words_d = words_q;
    idx_d   = idx_q;
    n_d     = n_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          idx_d   = '0;
          we_d    = 1'b1;
          waddr_d = '0;
          wdata_d = NOP_WORD;
        end
      end
      S_CLEAR: begin
        if (waddr_q == LAST_ADDR) begin
          state_d = S_COUNT;
        end else begin
          we_d    = 1'b1;
          waddr_d = waddr_q + ADDR_W'(1);
          wdata_d = NOP_WORD;
        end
      end
      S_COUNT: begin
        if (accept) begin
          bcnt_d = '0;
          if (bus.rx_data == 8'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
            words_d = '0;
          end else if ({1'b0, bus.rx_data} > DEPTH9) begin
            err_d   = 1'b1;
            n_d     = DEPTH9;
            state_d = S_BYTES;
          end else begin
            n_d     = {1'b0, bus.rx_data};
            state_d = S_BYTES;
          end
        end
      end
      S_BYTES: begin
        if (accept) begin
          word_d[{bcnt_q, 3'b000} +: 8] = bus.rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            waddr_d = idx_q[ADDR_W-1:0];
            wdata_d = word_d;
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_q + IW'(1);
        if (32'(idx_q) + 32'd1 == 32'(n_q)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
          words_d = n_q;
        end else begin
          state_d = S_BYTES;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_COUNT) || (state_d == S_BYTES);
    busy_d     = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= BOOT_HOLD;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
      idx_q      <= '0;
      n_q        <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      words_q    <= words_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
    end
  end

  assign bus.rx_ready    = rx_ready_q;
  assign bus.we          = we_q;
  assign bus.waddr       = waddr_q;
  assign bus.wdata       = wdata_q;
  assign cpu_hold_o      = hold_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign words_loaded_o  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a scoreboard of expected RAM writes built from the byte stream,
// one negedge compare process, and literal checks on the resulting memory image.
module tb_imem_loader;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          need;   // bytes that must have been accepted before this write
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;       // 0: DEPTH=256 instance, 1: DEPTH=16 instance
  logic       start_a, start_b;
  logic [7:0] rx_data;
  logic       rx_valid;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8)) bus_a ();
  imem_loader_if #(.ADDR_W(8)) bus_b ();

  logic       hold_a, busy_a, done_a, err_a, hold_b, busy_b, done_b, err_b;
  logic [8:0] wl_a, wl_b;

  assign bus_a.rx_data  = rx_data;
  assign bus_a.rx_valid = rx_valid & ~sel;
  assign bus_b.rx_data  = rx_data;
  assign bus_b.rx_valid = rx_valid & sel;

  imem_loader #(.ADDR_W(8), .DEPTH(256), .NOP_WORD(NOP), .BOOT_HOLD(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .bus(bus_a),
    .cpu_hold_o(hold_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
    .words_loaded_o(wl_a)
  );

  imem_loader #(.ADDR_W(8), .DEPTH(16), .NOP_WORD(NOP), .BOOT_HOLD(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .bus(bus_b),
    .cpu_hold_o(hold_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
    .words_loaded_o(wl_b)
  );

  // Observed outputs of whichever instance is under test.
  logic        o_we, o_rdy, o_hold, o_busy, o_done, o_err;
  logic [7:0]  o_waddr;
  logic [31:0] o_wdata;
  logic [8:0]  o_wl;
  assign o_we    = sel ? bus_b.we       : bus_a.we;
  assign o_rdy   = sel ? bus_b.rx_ready : bus_a.rx_ready;
  assign o_waddr = sel ? bus_b.waddr    : bus_a.waddr;
  assign o_wdata = sel ? bus_b.wdata    : bus_a.wdata;
  assign o_hold  = sel ? hold_b : hold_a;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_done  = sel ? done_b : done_a;
  assign o_err   = sel ? err_b  : err_a;
  assign o_wl    = sel ? wl_b   : wl_a;

  int          total = 0;
  int          bad   = 0;
  wr_t         exp_q[$];
  wr_t         cur;
  int          exp_words;
  logic        exp_err;
  int          depth;
  int          acc_cnt;
  logic [7:0]  byte_q[$];
  logic [31:0] img [256];
  logic [31:0] ram [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // The instruction RAM the loader writes into.
  always @(posedge clk) if (!rst && o_we) ram[o_waddr] <= o_wdata;

  // Scoreboard: every write must be the next one predicted, and every done pulse must report the model's totals.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_we) begin
        check("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("wr_addr", 32'(o_waddr), 32'(cur.addr));
          check("wr_data", o_wdata, cur.data);
          check("bytes_before_write", 32'(acc_cnt >= cur.need), 1);
        end
      end
      if (o_done) begin
        check("done_words", 32'(o_wl), 32'(exp_words));
        check("done_err", 32'(o_err), 32'(exp_err));
        check("done_hold", 32'(o_hold), 0);
        check("done_busy", 32'(o_busy), 1);
        check("done_drained", 32'(exp_q.size()), 0);
      end
    end
  end

  // Model: DEPTH NOP writes, then the clamped number of little-endian words from the stream.
  task automatic build_expect(output int nsend);
    wr_t e;
    int  n, nc;
    depth = sel ? 16 : 256;
    exp_q.delete();
    for (int a = 0; a < depth; a++) begin
      e.addr = a; e.data = NOP; e.need = 0;
      exp_q.push_back(e);
      img[a] = NOP;
    end
    n = int'(byte_q[0]);
    nc = (n > depth) ? depth : n;
    exp_err = (n > depth);
    exp_words = nc;
    for (int w = 0; w < nc; w++) begin
      e.addr = w;
      e.data = 32'(byte_q[1+4*w]) + (32'(byte_q[2+4*w]) << 8) +
               (32'(byte_q[3+4*w]) << 16) + (32'(byte_q[4+4*w]) << 24);
      e.need = 1 + 4 * (w + 1);
      exp_q.push_back(e);
      img[w] = e.data;
    end
    nsend = 1 + 4 * nc;
  endtask

  // A junk byte is offered alongside start; it must not be taken as the header.
  task automatic pulse_start();
    @(posedge clk); #1;
    rx_data = 8'hAA; rx_valid = 1'b1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data = b; rx_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (o_rdy) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (ok) acc_cnt++;
    check("byte_accepted", 32'(ok), 1);
  endtask

  task automatic offer_reject(input logic [7:0] b, input int cycles);
    rx_data = b; rx_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("extra_byte_refused", 32'(o_rdy), 0);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (o_done) begin ok = 1; break; end
    end
    check("done_seen", 32'(ok), 1);
    @(negedge clk);
    check("after_done_busy", 32'(o_busy), 0);
    check("after_done_done", 32'(o_done), 0);
    check("after_done_hold", 32'(o_hold), 0);
    check("after_done_ready", 32'(o_rdy), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_image();
    for (int a = 0; a < depth; a++) check("image", ram[a], img[a]);
  endtask

  task automatic run_load(input int max_gap, input bit extra_start);
    int nsend;
    build_expect(nsend);
    acc_cnt = 0;
    pulse_start();
    @(negedge clk);
    check("start_hold", 32'(o_hold), 1);
    check("start_busy", 32'(o_busy), 1);
    check("start_err_clear", 32'(o_err), 0);
    @(posedge clk); #1;
    if (extra_start) begin
      repeat (5) begin @(posedge clk); #1; end
      pulse_start();
    end
    for (int i = 0; i < nsend; i++)
      send_byte(byte_q[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    wait_done();
    check_image();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_we"},    32'(o_we), 0);
    check({tag, "_waddr"}, 32'(o_waddr), 0);
    check({tag, "_wdata"}, o_wdata, 0);
    check({tag, "_ready"}, 32'(o_rdy), 0);
    check({tag, "_busy"},  32'(o_busy), 0);
    check({tag, "_done"},  32'(o_done), 0);
    check({tag, "_err"},   32'(o_err), 0);
    check({tag, "_words"}, 32'(o_wl), 0);
    check({tag, "_hold"},  32'(o_hold), 1);
  endtask

  function automatic void set_prog2();
    byte_q = '{8'h02, 8'h93, 8'h02, 8'h00, 8'h00, 8'h83, 8'h22, 8'h90, 8'h02};
  endfunction

  initial begin
    int nsend;
    rst = 1'b1; sel = 1'b0; start_a = 1'b0; start_b = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    // Reset while idle.
    rst = 1'b1; #1;
    check_reset("idle_rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-word program.
    set_prog2();
    run_load(0, 1'b0);
    check("p2_word0", ram[0], 32'h0000_0293);
    check("p2_word1", ram[1], 32'h0290_2283);
    check("p2_word2_nop", ram[2], NOP);
    check("p2_words", 32'(o_wl), 2);
    check("p2_hold", 32'(o_hold), 0);

    // Same program with idle gaps between bytes.
    run_load(5, 1'b0);
    check("gap_word1", ram[1], 32'h0290_2283);
    check("gap_words", 32'(o_wl), 2);

    // Empty program: only the clear, and nothing more is taken.
    byte_q = '{8'h00};
    run_load(0, 1'b0);
    check("empty_words", 32'(o_wl), 0);
    check("empty_word0_nop", ram[0], NOP);
    offer_reject(8'h55, 10);

    // Oversized header on the 16-word instance: clamped with err.
    sel = 1'b1;
    byte_q = '{8'h14};
    for (int i = 0; i < 80; i++) byte_q.push_back(8'(i + 1));
    run_load(0, 1'b0);
    check("clamp_err", 32'(o_err), 1);
    check("clamp_words", 32'(o_wl), 16);
    check("clamp_word15", ram[15], 32'h403F_3E3D);
    offer_reject(byte_q[65], 10);
    check("clamp_err_sticky", 32'(o_err), 1);

    // The next start clears err.
    byte_q = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    run_load(0, 1'b0);
    check("reload_word0", ram[0], 32'h4433_2211);
    check("reload_err", 32'(o_err), 0);

    // Reset in the middle of a word, then a full reload with a stray start during clear.
    sel = 1'b0;
    set_prog2();
    build_expect(nsend);
    acc_cnt = 0;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h93, 0);
    send_byte(8'h02, 0);
    #2 rst = 1'b1;
    #1 check_reset("mid_rst");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_load(0, 1'b1);
    check("rl_word0", ram[0], 32'h0000_0293);
    check("rl_word1", ram[1], 32'h0290_2283);
    check("rl_words", 32'(o_wl), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
